// File: rtl/cb_edge_cap_mc.sv
// Multi-channel edge capture: synchroniser, optional glitch filter, edge pulses, W1C sticky flags
// and masked interrupt. Define CB_EDGE_CAP_FLT_EN to compile in the per-channel glitch filter.
module cb_edge_cap_mc #(
  parameter int          U_DLY    = 1,
  parameter int unsigned CH_NUM   = 8,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned FLT_CYC  = 4
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [CH_NUM-1:0] sig_in,
  output logic [CH_NUM-1:0] edge_r,
  output logic [CH_NUM-1:0] edge_f,
  output logic [CH_NUM-1:0] edge_rf,
  output logic [CH_NUM-1:0] sig_lvl,
  input  logic [CH_NUM-1:0] sticky_clr,
  output logic [CH_NUM-1:0] edge_sticky,
  input  logic [CH_NUM-1:0] irq_mask,
  output logic              irq
);

  if (CH_NUM < 1 || CH_NUM > 32 || SYNC_STG < 2 || SYNC_STG > 4 ||
      FLT_CYC < 1 || FLT_CYC > 65535 || U_DLY < 0) begin : g_param_chk
    $error("cb_edge_cap_mc: parameter out of range");
  end

  logic [CH_NUM-1:0] s_sync;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STG-1:0] sync_q;
    logic lvl_q;
    logic lvl_d_q;
    logic r_q;
    logic f_q;
    logic rf_q;
    logic sticky_q;

    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STG-2:0], sig_in[i]};
      end
    end

    assign s_sync[i] = sync_q[SYNC_STG-1];

`ifdef CB_EDGE_CAP_FLT_EN
    localparam int unsigned CntW = $clog2(FLT_CYC + 1);
    logic [CntW-1:0] cnt_q;

    // Level only moves after FLT_CYC consecutive cycles of disagreement; any agreement restarts.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (s_sync[i] == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FLT_CYC - 1)) begin
        cnt_q <= '0;
        lvl_q <= s_sync[i];
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
`else
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        lvl_q <= 1'b0;
      end else begin
        lvl_q <= s_sync[i];
      end
    end
`endif

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
        lvl_d_q  <= 1'b0;
        r_q      <= 1'b0;
        f_q      <= 1'b0;
        rf_q     <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        lvl_d_q  <= lvl_q;
        r_q      <= ~lvl_d_q & lvl_q;
        f_q      <= lvl_d_q & ~lvl_q;
        rf_q     <= lvl_d_q ^ lvl_q;
        sticky_q <= (sticky_q & ~sticky_clr[i]) | (lvl_d_q ^ lvl_q);
      end
    end

    assign sig_lvl[i]     = lvl_q;
    assign edge_r[i]      = r_q;
    assign edge_f[i]      = f_q;
    assign edge_rf[i]     = rf_q;
    assign edge_sticky[i] = sticky_q;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_sticky & irq_mask);
    end
  end

endmodule

// File: tb/tb_cb_edge_cap_mc.sv
// Bench for cb_edge_cap_mc: queue-based reference model compared every cycle plus directed checks.
module tb_cb_edge_cap_mc;

  localparam int unsigned CH_NUM   = 32;
  localparam int unsigned SYNC_STG = 2;
  localparam int unsigned FLT_CYC  = 4;
`ifdef CB_EDGE_CAP_FLT_EN
  localparam int unsigned LAT = SYNC_STG + FLT_CYC;
`else
  localparam int unsigned LAT = SYNC_STG + 1;
`endif

  logic              clk_sys = 1'b0;
  logic              rst;
  logic [CH_NUM-1:0] sig_in;
  logic [CH_NUM-1:0] edge_r;
  logic [CH_NUM-1:0] edge_f;
  logic [CH_NUM-1:0] edge_rf;
  logic [CH_NUM-1:0] sig_lvl;
  logic [CH_NUM-1:0] sticky_clr;
  logic [CH_NUM-1:0] edge_sticky;
  logic [CH_NUM-1:0] irq_mask;
  logic              irq;

  cb_edge_cap_mc #(
    .U_DLY   (1),
    .CH_NUM  (CH_NUM),
    .SYNC_STG(SYNC_STG),
    .FLT_CYC (FLT_CYC)
  ) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .sig_in     (sig_in),
    .edge_r     (edge_r),
    .edge_f     (edge_f),
    .edge_rf    (edge_rf),
    .sig_lvl    (sig_lvl),
    .sticky_clr (sticky_clr),
    .edge_sticky(edge_sticky),
    .irq_mask   (irq_mask),
    .irq        (irq)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [CH_NUM-1:0] act,
                     input logic [CH_NUM-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  // Reference model: inputs seen through a SYNC_STG-deep sample queue, then level/edge rules.
  logic [CH_NUM-1:0] m_q[$];
  logic [CH_NUM-1:0] old_sync;
  logic [CH_NUM-1:0] m_lvl, m_lvl_d, m_r, m_f, m_rf, m_sticky;
  logic              m_irq;
`ifdef CB_EDGE_CAP_FLT_EN
  int unsigned       m_cnt[CH_NUM];
`endif

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_lvl = '0; m_lvl_d = '0; m_r = '0; m_f = '0; m_rf = '0; m_sticky = '0; m_irq = 1'b0;
`ifdef CB_EDGE_CAP_FLT_EN
      for (int c = 0; c < CH_NUM; c++) m_cnt[c] = 0;
`endif
    end else begin
      old_sync = (m_q.size() == SYNC_STG) ? m_q[0] : '0;
      m_q.push_back(sig_in);
      if (m_q.size() > SYNC_STG) void'(m_q.pop_front());
      m_irq    = |(m_sticky & irq_mask);
      m_sticky = (m_sticky & ~sticky_clr) | (m_lvl_d ^ m_lvl);
      m_r      = ~m_lvl_d & m_lvl;
      m_f      = m_lvl_d & ~m_lvl;
      m_rf     = m_lvl_d ^ m_lvl;
      m_lvl_d  = m_lvl;
`ifdef CB_EDGE_CAP_FLT_EN
      for (int c = 0; c < CH_NUM; c++) begin
        if (old_sync[c] == m_lvl[c]) begin
          m_cnt[c] = 0;
        end else if (m_cnt[c] == FLT_CYC - 1) begin
          m_lvl[c] = old_sync[c];
          m_cnt[c] = 0;
        end else begin
          m_cnt[c]++;
        end
      end
`else
      m_lvl = old_sync;
`endif
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en && !rst) begin
      cmp("edge_r", edge_r, m_r);
      cmp("edge_f", edge_f, m_f);
      cmp("edge_rf", edge_rf, m_rf);
      cmp("sig_lvl", sig_lvl, m_lvl);
      cmp("edge_sticky", edge_sticky, m_sticky);
      cmp("irq", CH_NUM'(irq), CH_NUM'(m_irq));
    end
  end

  initial begin
    rst = 1'b1; sig_in = '0; sticky_clr = '0; irq_mask = '0;
    sig_in[4] = 1'b1;
    ticks(3);
    cmp("rst_sticky", edge_sticky, '0);
    cmp("rst_lvl", sig_lvl, '0);
    cmp("rst_irq", CH_NUM'(irq), '0);

    // Ch0 rises just after release; ch4 was high through reset.
    rst = 1'b0; chk_en = 1'b1;
    irq_mask[0] = 1'b1; sig_in[0] = 1'b1;
    ticks(LAT);
    cmp("lvl_before_pulse", sig_lvl, 32'h0000_0011);
    cmp("no_pulse_yet", edge_rf, '0);
    ticks(1);
    cmp("first_edge_r", edge_r, 32'h0000_0011);
    cmp("first_edge_rf", edge_rf, 32'h0000_0011);
    cmp("first_edge_f", edge_f, '0);
    cmp("first_sticky", edge_sticky, 32'h0000_0011);
    cmp("irq_not_yet", CH_NUM'(irq), '0);
    ticks(1);
    cmp("pulse_one_cycle", edge_r, '0);
    cmp("irq_rise", CH_NUM'(irq), 32'h1);

    sticky_clr[0] = 1'b1;
    ticks(1);
    sticky_clr = '0;
    cmp("w1c_sticky", edge_sticky, 32'h0000_0010);
    cmp("irq_hold", CH_NUM'(irq), 32'h1);
    ticks(1);
    cmp("irq_fall", CH_NUM'(irq), '0);

    // Ch1: short glitch then a longer pulse.
    sig_in[1] = 1'b1; ticks(3); sig_in[1] = 1'b0;
    ticks(LAT + 4);
`ifdef CB_EDGE_CAP_FLT_EN
    cmp("glitch_rejected", edge_sticky & 32'h2, '0);
`endif
    sig_in[1] = 1'b1; ticks(6); sig_in[1] = 1'b0;
    ticks(LAT + 6);
    cmp("long_pulse_seen", edge_sticky & 32'h2, 32'h2);
    cmp("long_pulse_low", sig_lvl & 32'h2, '0);

    // Ch2: clear strobe lands on the same edge as the new edge.
    irq_mask = 32'h4;
    sig_in[2] = 1'b1;
    ticks(LAT);
    sticky_clr[2] = 1'b1;
    ticks(1);
    sticky_clr = '0;
    cmp("collide_rf", edge_rf, 32'h4);
    cmp("collide_set_wins", edge_sticky & 32'h4, 32'h4);
    ticks(1);
    cmp("collide_irq", CH_NUM'(irq), 32'h1);
    sticky_clr[2] = 1'b1;
    ticks(1);
    sticky_clr = '0;
    cmp("clr2_sticky", edge_sticky & 32'h4, '0);
    ticks(1);
    cmp("clr2_irq", CH_NUM'(irq), '0);

    // Ch3: masked sticky, then unmask.
    irq_mask = '0;
    sig_in[3] = 1'b1;
    ticks(LAT + 2);
    cmp("masked_sticky", edge_sticky & 32'h8, 32'h8);
    cmp("masked_irq", CH_NUM'(irq), '0);
    irq_mask[3] = 1'b1;
    ticks(1);
    cmp("unmask_irq", CH_NUM'(irq), 32'h1);

    // All channels with independent, slowly toggling patterns.
    for (int k = 0; k < 400; k++) begin
      sig_in     = sig_in ^ ($urandom & $urandom & $urandom);
      sticky_clr = $urandom & $urandom;
      irq_mask   = $urandom;
      ticks(1);
    end

    // Reset mid-count with inputs high, then release.
    sticky_clr = '0; irq_mask = '1;
    sig_in = 32'hA5A5_0F0F;
    ticks(LAT + 3);
    sig_in = 32'h5A5A_F0F0;
    ticks(SYNC_STG + 1);
    rst = 1'b1;
    #1;
    cmp("rst_async_r", edge_r | edge_f | edge_rf, '0);
    cmp("rst_async_lvl", sig_lvl, '0);
    cmp("rst_async_sticky", edge_sticky, '0);
    cmp("rst_async_irq", CH_NUM'(irq), '0);
    ticks(2);
    rst = 1'b0;
    ticks(LAT + 1);
    cmp("release_edge_r", edge_r, 32'h5A5A_F0F0);
    ticks(4);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
